shift_stream_stage: RTL and testbench

Registered streaming front-end for the combinational 16-bit barrel shifter: it accepts shift requests over a valid/ready handshake, holds them in an input register, drives the shifter, and captures the result in an output register with full backpressure. It sits between the operand source and the result consumer. It extends the shift amount to 5 bits, saturates out-of-range shifts, and counts completed transactions.

---
 rtl/shift_stream_stage_pkg.sv | 21 ++
 rtl/barrel_shifter.sv | 24 ++
 rtl/shift_stream_stage.sv | 97 +++++++++
 tb/tb_shift_stream_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_stream_stage_pkg.sv
// Shared constants and types for the registered barrel-shifter stream stage.
package shift_stream_stage_pkg;

   localparam int unsigned SHIFT_W   = 16;
   localparam int unsigned AMT_W     = 5;
   localparam logic [SHIFT_W-1:0] SAT_VALUE = 16'hFFFF;
   localparam logic DIR_DN = 1'b0;
   localparam logic DIR_UP = 1'b1;

   typedef struct packed {
      logic [SHIFT_W-1:0] data;
      logic [AMT_W-1:0]   amt;
      logic               dir;
   } req_t;

   // Amounts of 16 or more bypass the shifter entirely.
   function automatic logic amt_saturates(logic [AMT_W-1:0] amt);
      return amt[AMT_W-1];
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 16-bit barrel shifter; vacated bit positions fill with 1.
module barrel_shifter
   import shift_stream_stage_pkg::*;
(
   input  logic [15:0] a,
   input  logic [3:0]  s,
   input  logic        lr,
   output logic [15:0] y
);

   logic [31:0] wide;

   always_comb begin
      wide = '0;
      if (lr == DIR_UP) begin
         wide = {a, 16'hFFFF} << s;
         y    = wide[31:16];
      end else begin
         wide = {16'hFFFF, a} >> s;
         y    = wide[15:0];
      end
   end

endmodule

// File: rtl/shift_stream_stage.sv
// Two-register valid/ready wrapper around barrel_shifter with saturation and
// a completed-transaction counter.
module shift_stream_stage
   import shift_stream_stage_pkg::*;
#(
   parameter int unsigned W     = SHIFT_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic [4:0]       in_amt,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_sat,
   output logic [CNT_W-1:0] done_cnt
);

   req_t             s1_q, s1_d;
   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     res_q, res_d;
   logic             sat_q, sat_d;
   logic             s2_valid_q, s2_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic         s2_free;
   logic         s1_load;
   logic         s2_load;
   logic [15:0]  shift_y;

   barrel_shifter u_shifter (
      .a  (s1_q.data),
      .s  (s1_q.amt[3:0]),
      .lr (s1_q.dir),
      .y  (shift_y)
   );

   always_comb begin
      s2_free  = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_free;
      s1_load  = in_valid && in_ready;
      s2_load  = s1_valid_q && s2_free;

      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (s1_load) begin
         s1_d       = '{data: in_data, amt: in_amt, dir: in_dir};
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      res_d      = res_q;
      sat_d      = sat_q;
      s2_valid_d = s2_valid_q;
      if (s2_load) begin
         sat_d      = amt_saturates(s1_q.amt);
         res_d      = sat_d ? SAT_VALUE : shift_y;
         s2_valid_d = 1'b1;
      end else if (out_ready && s2_valid_q) begin
         s2_valid_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (s2_valid_q && out_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         res_q      <= '0;
         sat_q      <= 1'b0;
         s2_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         res_q      <= res_d;
         sat_q      <= sat_d;
         s2_valid_q <= s2_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = res_q;
   assign out_sat   = sat_q;
   assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_stream_stage.sv
// Directed plus random bench for shift_stream_stage with a bit-level reference
// model and an in-order scoreboard of expected results.
module tb_shift_stream_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [4:0]  in_amt = '0;
   logic        in_dir = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_sat;
   logic [15:0] done_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [16:0] exp_q[$];
   logic [15:0] exp_cnt = '0;
   int          pops = 0;
   logic        acc;
   logic [15:0] last_data;
   logic        last_sat;
   logic [15:0] held;
   int          pops0;

   shift_stream_stage #(.W(16), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   // Reference: {sat, result}, built bit by bit from the shift contract.
   function automatic logic [16:0] ref_op(logic [15:0] d, logic [4:0] a, logic dir);
      logic [15:0] r;
      int          src;
      if (a >= 5'd16) return {1'b1, 16'hFFFF};
      for (int i = 0; i < 16; i++) begin
         src  = dir ? i - int'(a) : i + int'(a);
         r[i] = (src >= 0 && src < 16) ? d[src] : 1'b1;
      end
      return {1'b0, r};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Sample handshakes at the falling edge, then return 1 time unit after the
   // next rising edge so the caller can drive new inputs.
   task automatic step();
      logic [16:0] e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[15:0]));
            chk("out_sat", 32'(out_sat), 32'(e[16]));
         end
         last_data = out_data;
         last_sat  = out_sat;
         pops++;
         exp_cnt++;
      end
      if (acc) exp_q.push_back(ref_op(in_data, in_amt, in_dir));
      @(posedge clk);
      #1;
      chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
   endtask

   task automatic send(logic [15:0] d, logic [4:0] a, logic dir);
      logic got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_dir   = dir;
      for (int i = 0; i < 50 && !got; i++) begin
         step();
         got = acc;
      end
      in_valid = 1'b0;
      chk("accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) step();
      chk("drain_timeout", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      exp_cnt  = '0;
      pops     = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();

      // Single request: two-cycle latency and first count.
      out_ready = 1'b1;
      send(16'h1234, 5'd4, 1'b0);
      step();
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_data", 32'(out_data), 32'h0000F123);
      chk("t1_out_sat", 32'(out_sat), 32'd0);
      step();
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);

      send(16'h0001, 5'd3, 1'b1);
      drain();
      chk("up3", 32'(last_data), 32'h0000000F);
      send(16'h8000, 5'd15, 1'b0);
      drain();
      chk("dn15_data", 32'(last_data), 32'h0000FFFF);
      chk("dn15_sat", 32'(last_sat), 32'd0);
      send(16'h0000, 5'd20, 1'b1);
      drain();
      chk("sat_data", 32'(last_data), 32'h0000FFFF);
      chk("sat_flag", 32'(last_sat), 32'd1);
      send(16'hA5A5, 5'd0, 1'($urandom));
      drain();
      chk("amt0", 32'(last_data), 32'h0000A5A5);

      // Backpressure: two accepts fill the stage, then it stalls.
      pops0     = pops;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_amt    = 5'($urandom);
      in_dir    = 1'($urandom);
      step();
      chk("bp_acc0", 32'(acc), 32'd1);
      in_data = 16'($urandom);
      in_amt  = 5'($urandom);
      in_dir  = 1'($urandom);
      step();
      chk("bp_acc1", 32'(acc), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_first", 32'(out_data), 32'(exp_q[0][15:0]));
      held    = out_data;
      in_data = 16'($urandom);
      in_amt  = 5'($urandom);
      in_dir  = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_acc", 32'(acc), 32'd0);
         chk("bp_hold", 32'(out_data), 32'(held));
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_full_accept", 32'(acc), 32'd1);
      send(16'($urandom), 5'($urandom), 1'($urandom));
      drain();
      chk("bp_count", 32'(pops - pops0), 32'd4);

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom);
         in_data   = 16'($urandom);
         in_amt    = 5'($urandom);
         in_dir    = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      drain();

      // Full throughput from a clean reset.
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_data = 16'($urandom);
         in_amt  = 5'($urandom);
         in_dir  = 1'($urandom);
         step();
         chk("tp_accept", 32'(acc), 32'd1);
      end
      in_valid = 1'b0;
      step();
      step();
      chk("tp_pops", 32'(pops), 32'd100);
      chk("tp_done_cnt", 32'(done_cnt), 32'd100);
      chk("tp_idle", 32'(out_valid), 32'd0);

      // Reset while both stages hold data.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_amt    = 5'($urandom);
      in_dir    = 1'($urandom);
      step();
      in_data = 16'($urandom);
      step();
      chk("full_before_rst", 32'(in_ready), 32'd0);
      do_reset();
      out_ready = 1'b1;
      send(16'h0F0F, 5'd2, 1'b1);
      drain();
      chk("post_rst_data", 32'(last_data), 32'h00003C3F);
      chk("post_rst_pops", 32'(pops), 32'd1);
      chk("post_rst_cnt", 32'(done_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
